// File: rtl/forward_arb_pkg.sv
// Shared definitions for the forwarder-side core arbiter: tag width helper and FSM encodings.
`ifndef FORWARD_ARB_CLOG2
`define FORWARD_ARB_CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package forward_arb_pkg;

  localparam logic [1:0] FA_IDLE  = 2'd0;
  localparam logic [1:0] FA_OFFER = 2'd1;
  localparam logic [1:0] FA_BUSY  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = FA_IDLE,
    ST_OFFER = FA_OFFER,
    ST_BUSY  = FA_BUSY
  } fa_state_e;

endpackage

// File: rtl/forward_arb_rr_pick.sv
// Rotating priority encoder: grants the first requester at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N      = 4,
  parameter int TAG_SZ = 2
) (
  input  logic [N-1:0]      req,
  input  logic [TAG_SZ-1:0] ptr,
  output logic [TAG_SZ-1:0] gnt_idx,
  output logic              any
);

  logic [TAG_SZ-1:0] idx;

  // Scan farthest-first so the candidate closest to ptr is written last and wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = TAG_SZ'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_arb.sv
// Forwarder-side arbiter: offers one core's accepted packet to the single forwarder,
// then steers reads and the done pulse to that core and muxes its read data back.
module forward_arb
  import forward_arb_pkg::*;
#(
  parameter int N                 = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int TAG_SZ            = `CLOG2(N),
  parameter int ORDERED           = 0,
  parameter int BUF_OUT           = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [SN_FWD_ADDR_WIDTH-1:0]          fwd_addr,
  input  logic                                  fwd_rd_en,
  output logic [SN_FWD_DATA_WIDTH-1:0]          fwd_rd_data,
  output logic                                  fwd_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]                 fwd_byte_len,
  input  logic                                  fwd_done,
  output logic                                  rdy_for_fwd,
  input  logic                                  rdy_for_fwd_ack,
  input  logic [N-1:0]                          rdy_for_fwd_i,
  output logic [N-1:0]                          rdy_for_fwd_ack_i,
  output logic [SN_FWD_ADDR_WIDTH-1:0]          fwd_addr_i,
  output logic [N-1:0]                          fwd_rd_en_i,
  input  logic [N-1:0][SN_FWD_DATA_WIDTH-1:0]   fwd_rd_data_i,
  input  logic [N-1:0]                          fwd_rd_data_vld_i,
  input  logic [N-1:0][PLEN_WIDTH-1:0]          fwd_byte_len_i,
  output logic [N-1:0]                          fwd_done_i,
  output logic [TAG_SZ-1:0]                     sel_tag
);

  fa_state_e               state_q, state_d;
  logic [TAG_SZ-1:0]       sel_q, sel_d, ptr_q, ptr_d, pick_idx;
  logic [PLEN_WIDTH-1:0]   len_q, len_d;
  logic [N-1:0]            elig;
  logic                    pick_any;
  logic [SN_FWD_DATA_WIDTH-1:0] rd_data_c;
  logic                    rd_vld_c;

  // In ordered mode only the core at ptr may be chosen, so the picker just confirms it.
  assign elig = (ORDERED != 0) ? (rdy_for_fwd_i & (N'(1) << ptr_q)) : rdy_for_fwd_i;

  rr_pick #(.N(N), .TAG_SZ(TAG_SZ)) u_pick (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    sel_d             = sel_q;
    ptr_d             = ptr_q;
    len_d             = len_q;
    rdy_for_fwd       = 1'b0;
    fwd_byte_len      = '0;
    rdy_for_fwd_ack_i = '0;
    fwd_rd_en_i       = '0;
    fwd_done_i        = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // A core withdrawing its packet before the ack drops the offer without moving ptr.
        if (!rdy_for_fwd_i[sel_q]) begin
          state_d = ST_IDLE;
        end else begin
          rdy_for_fwd  = 1'b1;
          fwd_byte_len = fwd_byte_len_i[sel_q];
          if (rdy_for_fwd_ack) begin
            rdy_for_fwd_ack_i[sel_q] = 1'b1;
            len_d                    = fwd_byte_len_i[sel_q];
            state_d                  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        fwd_byte_len        = len_q;
        fwd_rd_en_i[sel_q]  = fwd_rd_en;
        if (fwd_done) begin
          fwd_done_i[sel_q] = 1'b1;
          ptr_d             = (sel_q == TAG_SZ'(N - 1)) ? '0 : sel_q + 1'b1;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fwd_addr_i = fwd_addr;
  assign sel_tag    = sel_q;

  // Returned data is only routed while a packet is owned; stale beats after done are dropped.
  assign rd_data_c = (state_q == ST_BUSY) ? fwd_rd_data_i[sel_q] : '0;
  assign rd_vld_c  = (state_q == ST_BUSY) && fwd_rd_data_vld_i[sel_q];

  generate
    if (BUF_OUT != 0) begin : g_buf
      logic [SN_FWD_DATA_WIDTH-1:0] data_q;
      logic                         vld_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          data_q <= rd_data_c;
          vld_q  <= rd_vld_c;
        end
      end
      assign fwd_rd_data     = data_q;
      assign fwd_rd_data_vld = vld_q;
    end else begin : g_nobuf
      assign fwd_rd_data     = rd_data_c;
      assign fwd_rd_data_vld = rd_vld_c;
    end
  endgenerate

endmodule

// File: tb/tb_forward_arb.sv
// Bench for forward_arb: a round-robin buffered 4-core instance and an ordered unbuffered 3-core instance.
module tb_forward_arb;

  logic clk, rst;

  // Instance A: N=4, round-robin, buffered output.
  logic [7:0]        fa_addr;
  logic              fa_rd_en, fa_done, fa_ack;
  logic [63:0]       fa_data;
  logic              fa_vld, fa_rdy;
  logic [31:0]       fa_len;
  logic [1:0]        fa_sel;
  logic [3:0]        ca_rdy, ca_ack, ca_rden, ca_vld, ca_done;
  logic [7:0]        ca_addr;
  logic [3:0][63:0]  ca_data;
  logic [3:0][31:0]  ca_len;

  // Instance B: N=3, strictly ordered, unbuffered output.
  logic [7:0]        fb_addr;
  logic              fb_rd_en, fb_done, fb_ack;
  logic [63:0]       fb_data;
  logic              fb_vld, fb_rdy;
  logic [31:0]       fb_len;
  logic [1:0]        fb_sel;
  logic [2:0]        cb_rdy, cb_ack, cb_rden, cb_vld, cb_done;
  logic [7:0]        cb_addr;
  logic [2:0][63:0]  cb_data;
  logic [2:0][31:0]  cb_len;

  int n_ok, n_chk;
  logic [63:0] rdq[$];

  forward_arb #(.N(4), .ORDERED(0), .BUF_OUT(1)) dut_a (
    .clk(clk), .rst(rst), .fwd_addr(fa_addr), .fwd_rd_en(fa_rd_en), .fwd_rd_data(fa_data),
    .fwd_rd_data_vld(fa_vld), .fwd_byte_len(fa_len), .fwd_done(fa_done), .rdy_for_fwd(fa_rdy),
    .rdy_for_fwd_ack(fa_ack), .rdy_for_fwd_i(ca_rdy), .rdy_for_fwd_ack_i(ca_ack), .fwd_addr_i(ca_addr),
    .fwd_rd_en_i(ca_rden), .fwd_rd_data_i(ca_data), .fwd_rd_data_vld_i(ca_vld),
    .fwd_byte_len_i(ca_len), .fwd_done_i(ca_done), .sel_tag(fa_sel));

  forward_arb #(.N(3), .ORDERED(1), .BUF_OUT(0)) dut_b (
    .clk(clk), .rst(rst), .fwd_addr(fb_addr), .fwd_rd_en(fb_rd_en), .fwd_rd_data(fb_data),
    .fwd_rd_data_vld(fb_vld), .fwd_byte_len(fb_len), .fwd_done(fb_done), .rdy_for_fwd(fb_rdy),
    .rdy_for_fwd_ack(fb_ack), .rdy_for_fwd_i(cb_rdy), .rdy_for_fwd_ack_i(cb_ack), .fwd_addr_i(cb_addr),
    .fwd_rd_en_i(cb_rden), .fwd_rd_data_i(cb_data), .fwd_rd_data_vld_i(cb_vld),
    .fwd_byte_len_i(cb_len), .fwd_done_i(cb_done), .sel_tag(fb_sel));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core memory model for A: one-cycle read latency, data = {core, 0x100 + addr}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ca_vld  <= '0;
      ca_data <= '0;
    end else begin
      ca_vld <= ca_rden;
      for (int i = 0; i < 4; i++) ca_data[i] <= {32'(i), 32'h100 + 32'(ca_addr)};
    end
  end

  // Full packet on A: wait for offer, ack, issue nreads reads at addr 0.., then done.
  task automatic do_packet_a(input int nreads, output bit ok, output int wt, output logic [1:0] tag,
                             output logic [31:0] len_off, output logic [31:0] len_busy,
                             output logic [3:0] ackv, output logic [3:0] donev,
                             output logic [3:0] rden_or, output int lat, output int c2o);
    int first_core, first_out;
    ok = 1'b0; wt = 0; tag = '0; len_off = '0; len_busy = '0; ackv = '0; donev = '0;
    rden_or = '0; lat = -1; c2o = -1; first_core = -1; first_out = -1;
    rdq.delete();
    while (fa_rdy !== 1'b1 && wt < 20) begin @(negedge clk); wt++; end
    if (fa_rdy !== 1'b1) return;
    ok = 1'b1; tag = fa_sel; len_off = fa_len;
    fa_ack = 1'b1;
    #1 ackv = ca_ack;
    for (int c = 0; c < nreads + 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        fa_ack = 1'b0; ca_rdy[tag] = 1'b0; ca_len[tag] = $urandom;
        #1 len_busy = fa_len;
      end
      if (ca_vld[tag] === 1'b1 && first_core < 0) first_core = c;
      if (fa_vld === 1'b1) begin
        rdq.push_back(fa_data);
        if (first_out < 0) first_out = c;
      end
      fa_rd_en = (c < nreads); fa_addr = 8'(c);
      #1 rden_or = rden_or | ca_rden;
    end
    fa_done = 1'b1;
    #1 donev = ca_done;
    @(negedge clk);
    fa_done = 1'b0;
    lat = first_out;
    c2o = (first_out < 0 || first_core < 0) ? -1 : first_out - first_core;
  endtask

  task automatic pkt_b(output bit ok, output logic [1:0] tag, output logic [2:0] donev);
    int w;
    w = 0; ok = 1'b0; tag = '0; donev = '0;
    while (fb_rdy !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (fb_rdy !== 1'b1) return;
    ok = 1'b1; tag = fb_sel; fb_ack = 1'b1;
    @(negedge clk);
    fb_ack = 1'b0; cb_rdy[tag] = 1'b0;
    fb_done = 1'b1;
    #1 donev = cb_done;
    @(negedge clk);
    fb_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({fa_rdy, fa_vld, fa_data, fa_len, fa_sel, ca_ack, ca_rden, ca_done} !== '0)
      $display("FAIL reset_a: outputs %h want 0", {fa_rdy, fa_vld, fa_data, fa_len, fa_sel, ca_ack, ca_rden, ca_done});
    else n_ok++;
    n_chk++;
    if ({fb_rdy, fb_vld, fb_data, fb_len, fb_sel, cb_ack, cb_rden, cb_done, cb_addr} !== '0)
      $display("FAIL reset_b: outputs %h want 0", {fb_rdy, fb_vld, fb_data, fb_len, fb_sel, cb_ack, cb_rden, cb_done, cb_addr});
    else n_ok++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // All cores ready from ptr=0: strict rotation, minimum gap between packets.
  task automatic test_rr_order();
    bit ok; int wt, lat, c2o;
    logic [1:0] tag; logic [31:0] lo, lb; logic [3:0] av, dv, rv;
    for (int i = 0; i < 4; i++) ca_len[i] = 32'(i * 10 + 5);
    ca_rdy = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      do_packet_a(1, ok, wt, tag, lo, lb, av, dv, rv, lat, c2o);
      n_chk++;
      if (!ok || tag !== 2'(p % 4)) $display("FAIL rr_order[%0d]: core %0d want %0d", p, tag, p % 4);
      else n_ok++;
      n_chk++;
      if (wt !== 1 || lo !== 32'((p % 4) * 10 + 5)) $display("FAIL rr_gap_len[%0d]: wait %0d len %0d want 1 %0d", p, wt, lo, (p % 4) * 10 + 5);
      else n_ok++;
      ca_rdy[tag] = 1'b1;
      ca_len[tag] = 32'(tag * 10 + 5);
    end
    ca_rdy = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  // Single core ready; then check pointer moved past it.
  task automatic test_single();
    bit ok; int wt, lat, c2o;
    logic [1:0] tag; logic [31:0] lo, lb; logic [3:0] av, dv, rv;
    ca_rdy = 4'b0100; ca_len[2] = 32'd60;
    do_packet_a(2, ok, wt, tag, lo, lb, av, dv, rv, lat, c2o);
    n_chk++;
    if (!ok || tag !== 2'd2 || wt !== 1) $display("FAIL single_offer: ok %0d core %0d wait %0d want 1 2 1", ok, tag, wt);
    else n_ok++;
    n_chk++;
    if (lo !== 32'd60 || lb !== 32'd60) $display("FAIL single_len: offer %0d busy %0d want 60", lo, lb);
    else n_ok++;
    n_chk++;
    if (av !== 4'b0100 || dv !== 4'b0100) $display("FAIL single_pulses: ack %b done %b want 0100", av, dv);
    else n_ok++;
    ca_rdy = 4'b1011;
    do_packet_a(0, ok, wt, tag, lo, lb, av, dv, rv, lat, c2o);
    n_chk++;
    if (!ok || tag !== 2'd3) $display("FAIL ptr_after_done: core %0d want 3", tag);
    else n_ok++;
    ca_rdy = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  // Reads on core 1 through the output register: data, routing and latency.
  task automatic test_reads();
    bit ok; int wt, lat, c2o, bad;
    logic [1:0] tag; logic [31:0] lo, lb; logic [3:0] av, dv, rv;
    logic [63:0] exp;
    ca_rdy = 4'b0010; ca_len[1] = 32'd8;
    do_packet_a(8, ok, wt, tag, lo, lb, av, dv, rv, lat, c2o);
    n_chk++;
    if (!ok || tag !== 2'd1 || rdq.size() != 8) $display("FAIL reads_setup: core %0d beats %0d want 1 8", tag, rdq.size());
    else n_ok++;
    bad = 0;
    for (int k = 0; k < rdq.size(); k++) begin
      exp = {32'd1, 32'h100 + 32'(k)};
      if (rdq[k] !== exp) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL reads_data: %0d bad beats want 0", bad);
    else n_ok++;
    n_chk++;
    if (rv !== 4'b0010) $display("FAIL reads_route: rd_en_i seen %b want 0010", rv);
    else n_ok++;
    n_chk++;
    if (lat !== 2 || c2o !== 1) $display("FAIL reads_latency: %0d cyc (core->out %0d) want 2 (1)", lat, c2o);
    else n_ok++;
  endtask

  // Random readiness on A vs. first-ready-at-or-after-ptr reference.
  task automatic test_random_rr(input int mptr_in);
    bit ok; int wt, lat, c2o, bad, nr, mptr, expc;
    logic [1:0] tag; logic [31:0] lo, lb; logic [3:0] av, dv, rv, r;
    logic [31:0] explen;
    mptr = mptr_in;
    for (int it = 0; it < 12; it++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) ca_len[i] = $urandom_range(1, 1500);
      expc = -1;
      for (int k = 0; k < 4 && expc < 0; k++) if (r[(mptr + k) % 4]) expc = (mptr + k) % 4;
      explen = ca_len[expc];
      ca_rdy = r;
      nr = $urandom_range(0, 3);
      do_packet_a(nr, ok, wt, tag, lo, lb, av, dv, rv, lat, c2o);
      n_chk++;
      if (!ok || tag !== 2'(expc) || lo !== explen) $display("FAIL rand_pick[%0d]: core %0d len %0d want %0d %0d", it, tag, lo, expc, explen);
      else n_ok++;
      bad = (rdq.size() != nr) ? 1 : 0;
      for (int k = 0; k < rdq.size(); k++) if (rdq[k] !== {32'(expc), 32'h100 + 32'(k)}) bad++;
      n_chk++;
      if (bad != 0 || dv !== 4'(1 << expc)) $display("FAIL rand_xfer[%0d]: bad %0d done %b want 0 %b", it, bad, dv, 4'(1 << expc));
      else n_ok++;
      mptr = (expc + 1) % 4;
    end
    ca_rdy = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int w;
    ca_rdy = 4'b1000; w = 0;
    while (fa_rdy !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    n_chk++;
    if (fa_rdy !== 1'b1) $display("FAIL arst_offer: rdy %b want 1", fa_rdy);
    else n_ok++;
    fa_ack = 1'b1;
    @(negedge clk);
    fa_ack = 1'b0; ca_rdy = 4'b0000; fa_rd_en = 1'b1; fa_addr = 8'd3;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({fa_rdy, fa_vld, fa_data, fa_len, fa_sel, ca_ack, ca_rden, ca_done} !== '0)
      $display("FAIL arst_busy: outputs %h want 0", {fa_rdy, fa_vld, fa_data, fa_len, fa_sel, ca_ack, ca_rden, ca_done});
    else n_ok++;
    fa_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ca_rdy = 4'b0110; w = 0;
    while (fa_rdy !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    n_chk++;
    if (fa_rdy !== 1'b1 || fa_sel !== 2'd1 || w !== 1) $display("FAIL arst_after: rdy %b core %0d wait %0d want 1 1 1", fa_rdy, fa_sel, w);
    else n_ok++;
    ca_rdy = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  // Ordered mode on B: waits for the ptr core, wraps 2 -> 0.
  task automatic test_ordered();
    bit ok; int cnt;
    logic [1:0] tag; logic [2:0] dv;
    cb_rdy = 3'b001;
    pkt_b(ok, tag, dv);
    n_chk++;
    if (!ok || tag !== 2'd0) $display("FAIL ord_first: core %0d want 0", tag);
    else n_ok++;
    cb_rdy = 3'b100; cnt = 0;
    repeat (8) begin @(negedge clk); if (fb_rdy === 1'b1) cnt++; end
    n_chk++;
    if (cnt != 0) $display("FAIL ord_wait: %0d offer cycles want 0", cnt);
    else n_ok++;
    cb_rdy[1] = 1'b1;
    pkt_b(ok, tag, dv);
    n_chk++;
    if (!ok || tag !== 2'd1) $display("FAIL ord_next: core %0d want 1", tag);
    else n_ok++;
    pkt_b(ok, tag, dv);
    n_chk++;
    if (!ok || tag !== 2'd2 || dv !== 3'b100) $display("FAIL ord_last: core %0d done %b want 2 100", tag, dv);
    else n_ok++;
    cb_rdy = 3'b010; cnt = 0;
    repeat (6) begin @(negedge clk); if (fb_rdy === 1'b1) cnt++; end
    n_chk++;
    if (cnt != 0) $display("FAIL ord_wrap_wait: %0d offer cycles want 0", cnt);
    else n_ok++;
    cb_rdy[0] = 1'b1;
    pkt_b(ok, tag, dv);
    n_chk++;
    if (!ok || tag !== 2'd0) $display("FAIL ord_wrap: core %0d want 0", tag);
    else n_ok++;
  endtask

  task automatic test_random_ordered();
    bit ok; int mptr, cnt;
    logic [1:0] tag; logic [2:0] dv;
    mptr = 1;
    for (int it = 0; it < 10; it++) begin
      cb_rdy = cb_rdy | 3'($urandom_range(0, 7));
      if (cb_rdy[mptr] == 1'b0) begin
        cnt = 0;
        repeat (4) begin @(negedge clk); if (fb_rdy === 1'b1) cnt++; end
        n_chk++;
        if (cnt != 0) $display("FAIL rord_hold[%0d]: %0d offer cycles want 0", it, cnt);
        else n_ok++;
        cb_rdy[mptr] = 1'b1;
      end
      pkt_b(ok, tag, dv);
      n_chk++;
      if (!ok || tag !== 2'(mptr) || dv !== 3'(1 << mptr)) $display("FAIL rord_pick[%0d]: core %0d done %b want %0d", it, tag, dv, mptr);
      else n_ok++;
      mptr = (mptr + 1) % 3;
    end
  endtask

  initial begin
    n_ok = 0; n_chk = 0;
    fa_addr = '0; fa_rd_en = 1'b0; fa_done = 1'b0; fa_ack = 1'b0; ca_rdy = '0; ca_len = '0;
    fb_addr = '0; fb_rd_en = 1'b0; fb_done = 1'b0; fb_ack = 1'b0; cb_rdy = '0; cb_len = '0;
    cb_data = '0; cb_vld = '0;
    test_reset();
    test_rr_order();
    test_single();
    test_reads();
    test_random_rr(2);
    test_async_reset();
    test_ordered();
    test_random_ordered();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_ok, n_chk);
    $fatal(1);
  end

endmodule
